// File: rtl/lcd_timing_pkg.sv
// Shared constants and helpers for the LCD timing generator.
// Holds the 800x480 panel timing, the line/frame total helpers and the
// colour-bar palette used by the optional test pattern.
package lcd_timing_pkg;

   // 800x480 panel timing (pixels / lines)
   localparam int LCD_H_ACTIVE = 800;
   localparam int LCD_H_FP     = 40;
   localparam int LCD_H_SYNC   = 128;
   localparam int LCD_H_BP     = 88;
   localparam int LCD_V_ACTIVE = 480;
   localparam int LCD_V_FP     = 1;
   localparam int LCD_V_SYNC   = 3;
   localparam int LCD_V_BP     = 21;

   // Colour bars, left to right
   localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
   localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
   localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
   localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
   localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
   localparam logic [23:0] BAR_RED     = 24'hFF0000;
   localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
   localparam logic [23:0] BAR_BLACK   = 24'h000000;

   // One timing-pipeline stage: fetch request plus raw (unpolarised) sync flags
   typedef struct packed {
      logic req;
      logic hs;
      logic vs;
   } tstage_t;

   function automatic int h_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int v_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic logic [23:0] bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    return BAR_WHITE;
         3'd1:    return BAR_YELLOW;
         3'd2:    return BAR_CYAN;
         3'd3:    return BAR_GREEN;
         3'd4:    return BAR_MAGENTA;
         3'd5:    return BAR_RED;
         3'd6:    return BAR_BLUE;
         default: return BAR_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/lcd_axis_cnt.sv
// One timing axis: wrap counter ordered active, front porch, sync, back porch.
// Ports: clk/rst (sync, active-high), clr holds the count at 0, inc advances it;
// cnt is the position, active/sync flag the region, wrap is the carry-out.
module lcd_axis_cnt
   import lcd_timing_pkg::*;
#(
   parameter int ACTIVE = LCD_H_ACTIVE,
   parameter int FP     = LCD_H_FP,
   parameter int SYNC   = LCD_H_SYNC,
   parameter int BP     = LCD_H_BP,
   parameter int CW     = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] cnt,
   output logic          active,
   output logic          sync,
   output logic          wrap
);

   localparam int TOTAL = h_total(ACTIVE, FP, SYNC, BP);
   localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

   assign wrap   = inc && (cnt == LAST);
   // Compare at 32 bits so region bounds equal to 2^CW cannot alias to 0
   assign active = (32'(cnt) < ACTIVE);
   assign sync   = (32'(cnt) >= ACTIVE + FP) && (32'(cnt) < ACTIVE + FP + SYNC);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= wrap ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD panel timing generator: h/v counters, pixel fetch request, and a
// DATA_LAT-deep pipeline that aligns hsync/vsync/de/rgb with the fetched data.
// Ports: clk, rst (sync, active-high), en; pix_req/pix_x/pix_y/sof to the picture
// source, pix_data back from it; hsync/vsync/de/rgb to the panel.
// Optional build macro LCD_TIMING_TESTPAT_EN adds input tp_sel (colour bars).
module lcd_timing_gen
   import lcd_timing_pkg::*;
#(
   parameter int H_ACTIVE = LCD_H_ACTIVE,
   parameter int H_FP     = LCD_H_FP,
   parameter int H_SYNC   = LCD_H_SYNC,
   parameter int H_BP     = LCD_H_BP,
   parameter int V_ACTIVE = LCD_V_ACTIVE,
   parameter int V_FP     = LCD_V_FP,
   parameter int V_SYNC   = LCD_V_SYNC,
   parameter int V_BP     = LCD_V_BP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int DATA_LAT = 1,
   parameter int CW       = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
`ifdef LCD_TIMING_TESTPAT_EN
   input  logic          tp_sel,
`endif
   input  logic [23:0]   pix_data,
   output logic          pix_req,
   output logic [CW-1:0] pix_x,
   output logic [CW-1:0] pix_y,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [23:0]   rgb,
   output logic          sof
);

   localparam int H_TOTAL   = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL   = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

   if (DATA_LAT < 0 || DATA_LAT > 3) begin : g_bad_lat
      $error("lcd_timing_gen: DATA_LAT must be 0..3");
   end
   if ((64'd1 << CW) < 64'(MAX_TOTAL)) begin : g_bad_cw
      $error("lcd_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
   end

   logic [CW-1:0] h_cnt, v_cnt;
   logic          h_act, h_sync, h_wrap;
   logic          v_act, v_sync;
   // Frame carry is not needed: sof is decoded from (0,0) so it also fires
   // on the first frame after reset or enable.
   logic          v_wrap_unused;

   lcd_axis_cnt #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)) u_h_cnt (
      .clk(clk), .rst(rst), .clr(~en), .inc(en),
      .cnt(h_cnt), .active(h_act), .sync(h_sync), .wrap(h_wrap)
   );

   lcd_axis_cnt #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)) u_v_cnt (
      .clk(clk), .rst(rst), .clr(~en), .inc(h_wrap),
      .cnt(v_cnt), .active(v_act), .sync(v_sync), .wrap(v_wrap_unused)
   );

   logic    in_active;
   tstage_t pipe [DATA_LAT+1];   // pipe[0] is the pix_req cycle
   logic [23:0] src_dat;

   assign in_active = en && h_act && v_act;
   assign pix_req   = pipe[0].req;

`ifdef LCD_TIMING_TESTPAT_EN
   // Bar colour rides a parallel pipe so bars have exactly the data timing
   logic [2:0]  bar_idx;
   logic [23:0] bar_pipe [DATA_LAT+1];

   always_comb begin
      bar_idx = '0;
      for (int k = 1; k < 8; k++) begin
         if (32'(h_cnt) >= (k * H_ACTIVE) / 8) bar_idx = bar_idx + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i <= DATA_LAT; i++) bar_pipe[i] <= '0;
      end else begin
         bar_pipe[0] <= bar_colour(bar_idx);
         for (int i = 1; i <= DATA_LAT; i++) bar_pipe[i] <= bar_pipe[i-1];
      end
   end

   assign src_dat = tp_sel ? bar_pipe[DATA_LAT] : pix_data;
`else
   assign src_dat = pix_data;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i <= DATA_LAT; i++) pipe[i] <= '0;
         pix_x <= '0;
         pix_y <= '0;
         sof   <= 1'b0;
         de    <= 1'b0;
         rgb   <= '0;
         hsync <= ~HS_POL;
         vsync <= ~VS_POL;
      end else begin
         // Sync flags gated by en so the panel outputs idle while disabled
         pipe[0] <= '{req: in_active, hs: en && h_sync, vs: en && v_sync};
         for (int i = 1; i <= DATA_LAT; i++) pipe[i] <= pipe[i-1];
         if (in_active) begin
            pix_x <= h_cnt;
            pix_y <= v_cnt;
         end
         sof   <= en && (h_cnt == '0) && (v_cnt == '0);
         // pix_data is valid while the request sits in the last stage
         de    <= pipe[DATA_LAT].req;
         rgb   <= pipe[DATA_LAT].req ? src_dat : 24'h000000;
         hsync <= pipe[DATA_LAT].hs ? HS_POL : ~HS_POL;
         vsync <= pipe[DATA_LAT].vs ? VS_POL : ~VS_POL;
      end
   end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen: a default-timing instance (DATA_LAT=2)
// for line-level checks and a small-timing instance for frame/enable/reset checks.
module tb_lcd_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- instance A: default timing, DATA_LAT=2 ----------------
   logic        rst_a, en_a, tp_sel_a;
   logic [23:0] pix_data_a;
   logic        pix_req_a, hsync_a, vsync_a, de_a, sof_a;
   logic [10:0] pix_x_a, pix_y_a;
   logic [23:0] rgb_a;

   lcd_timing_gen #(.DATA_LAT(2)) dut_a (
      .clk(clk), .rst(rst_a), .en(en_a),
`ifdef LCD_TIMING_TESTPAT_EN
      .tp_sel(tp_sel_a),
`endif
      .pix_data(pix_data_a), .pix_req(pix_req_a), .pix_x(pix_x_a), .pix_y(pix_y_a),
      .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .rgb(rgb_a), .sof(sof_a)
   );

   // ---------------- instance B: 8/2/3/2 x 4/1/2/1 (15 x 8 = 120) ----------------
   logic        rst_b, en_b, tp_sel_b;
   logic [23:0] pix_data_b;
   logic        pix_req_b, hsync_b, vsync_b, de_b, sof_b;
   logic [3:0]  pix_x_b, pix_y_b;
   logic [23:0] rgb_b;

   lcd_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                    .DATA_LAT(1), .CW(4)) dut_b (
      .clk(clk), .rst(rst_b), .en(en_b),
`ifdef LCD_TIMING_TESTPAT_EN
      .tp_sel(tp_sel_b),
`endif
      .pix_data(pix_data_b), .pix_req(pix_req_b), .pix_x(pix_x_b), .pix_y(pix_y_b),
      .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .rgb(rgb_b), .sof(sof_b)
   );

   // Picture source for A: returns {00, x[7:0], 5A} two cycles after the request
   initial begin
      logic [23:0] m1, m2;
      m1 = '0;
      m2 = '0;
      pix_data_a = '0;
      forever begin
         @(posedge clk);
         #1;
         pix_data_a = m2;
         m2 = m1;
         m1 = {8'h00, pix_x_a[7:0], 8'h5A};
      end
   end

   initial begin
      int k, per, lo, decnt, last, nsof, vlo;
      bit found, prev;

      rst_a = 1'b1; en_a = 1'b0; tp_sel_a = 1'b0;
      rst_b = 1'b1; en_b = 1'b0; tp_sel_b = 1'b0;
      pix_data_b = 24'hABCDEF;

      // ---- reset state ----
      repeat (3) @(negedge clk);
      check("rst_de",    de_a, 0);
      check("rst_rgb",   rgb_a, 0);
      check("rst_req",   pix_req_a, 0);
      check("rst_sof",   sof_a, 0);
      check("rst_hsync", hsync_a, 1);
      check("rst_vsync", vsync_a, 1);

      // ---- start: first request, latency to de, data alignment ----
      rst_a = 1'b0; en_a = 1'b1;
      k = 0;
      while (!pix_req_a && k < 10) begin @(negedge clk); k++; end
      check("a_req_lat", k, 1);
      check("a_first_sof", sof_a, 1);
      check("a_first_x", pix_x_a, 0);
      check("a_first_y", pix_y_a, 0);
      k = 0;
      while (!de_a && k < 10) begin @(negedge clk); k++; end
      check("a_de_lat", k, 3);
      check("a_rgb0", rgb_a, 24'h00005A);
      @(negedge clk);
      check("a_rgb1", rgb_a, 24'h00015A);

      // ---- one line between hsync falls ----
      found = 1'b0; prev = hsync_a;
      for (int i = 0; i < 3000 && !found; i++) begin
         @(negedge clk);
         if (prev && !hsync_a) found = 1'b1;
         prev = hsync_a;
      end
      check("a_hs_fall", found, 1);
      per = 1; lo = 1; decnt = de_a ? 1 : 0; found = 1'b0; prev = hsync_a;
      for (int i = 0; i < 3000 && !found; i++) begin
         @(negedge clk);
         if (prev && !hsync_a) found = 1'b1;
         else begin
            per++;
            if (!hsync_a) lo++;
            if (de_a) decnt++;
         end
         prev = hsync_a;
      end
      check("a_hs_period", per, 1056);
      check("a_hs_low", lo, 128);
      check("a_de_per_line", decnt, 800);

`ifdef LCD_TIMING_TESTPAT_EN
      // ---- colour bars ----
      tp_sel_a = 1'b1;
      found = 1'b0; prev = de_a;
      for (int i = 0; i < 3000 && !found; i++) begin
         @(negedge clk);
         if (!prev && de_a) found = 1'b1;
         prev = de_a;
      end
      check("tp_de_rise", found, 1);
      for (int x = 0; x < 800; x++) begin
         if (x == 0)   check("tp_x0",   rgb_a, 24'hFFFFFF);
         if (x == 100) check("tp_x100", rgb_a, 24'hFFFF00);
         if (x == 799) check("tp_x799", rgb_a, 24'h000000);
         if (x != 799) @(negedge clk);
      end
      tp_sel_a = 1'b0;
`endif

      // ---- instance B: frame level ----
      check("b_rst_hsync", hsync_b, 1);
      rst_b = 1'b0; en_b = 1'b1;
      k = 0;
      while (!sof_b && k < 10) begin @(negedge clk); k++; end
      check("b_sof_first", k, 1);
      last = 0; nsof = 0; vlo = 0; decnt = 0;
      for (int i = 1; i <= 360; i++) begin
         @(negedge clk);
         if (sof_b) begin
            nsof++;
            check("b_sof_period", i - last, 120);
            last = i;
         end
         if (i <= 120) begin
            if (!vsync_b) vlo++;
            if (de_b) decnt++;
         end
      end
      check("b_sof_count", nsof, 3);
      check("b_vs_low", vlo, 30);
      check("b_de_frame", decnt, 32);

      // ---- enable drop at x=5, y=2 ----
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (pix_req_b && pix_x_b == 4'd5 && pix_y_b == 4'd2) found = 1'b1;
      end
      check("b_drop_pt", found, 1);
      en_b = 1'b0;
      @(negedge clk);
      check("b_drop_req", pix_req_b, 0);
      check("b_drop_xhold", pix_x_b, 5);
      check("b_drop_sof", sof_b, 0);
      k = 0;
      while (de_b && k < 10) begin @(negedge clk); k++; end
      check("b_drop_de_lat", k, 2);
      check("b_drop_hs", hsync_b, 1);
      check("b_drop_vs", vsync_b, 1);
      repeat (3) @(negedge clk);
      check("b_idle_req", pix_req_b, 0);
      check("b_idle_de", de_b, 0);
      en_b = 1'b1;
      @(negedge clk);
      check("b_reen_req", pix_req_b, 1);
      check("b_reen_sof", sof_b, 1);
      check("b_reen_x", pix_x_b, 0);
      check("b_reen_y", pix_y_b, 0);
      k = 0;
      while (!de_b && k < 10) begin @(negedge clk); k++; end
      check("b_reen_de_lat", k, 2);
      check("b_rgb", rgb_b, 24'hABCDEF);

      // ---- reset mid-frame with de active ----
      rst_b = 1'b1;
      @(negedge clk);
      check("b_mrst_de", de_b, 0);
      check("b_mrst_rgb", rgb_b, 0);
      check("b_mrst_req", pix_req_b, 0);
      check("b_mrst_hs", hsync_b, 1);
      check("b_mrst_x", pix_x_b, 0);
      rst_b = 1'b0;
      @(negedge clk);
      check("b_post_req", pix_req_b, 1);
      check("b_post_sof", sof_b, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
